mem2d_ctrl: RTL and testbench
=============================

# mem2d_ctrl

Two-port round-robin access controller and bulk-clear sequencer for the 64 x 32 x 8 two-dimensional memory (`mem2d`). It arbitrates read and write requests from two requesters onto the single `addr_x` / `addr_y` / `data_in` / `wr` / `data_out` port. It generates a setup/strobe sequence so that address and data are stable before `wr` rises. On command, it sweeps every location to zero.

## Interface
- `AW_X`, default 6: x-address width (`mem2d` `addr_x`).
- `AW_Y`, default 5: y-address width (`mem2d` `addr_y`).
- `DW`, default 8: data width.
- Clock and reset: one clock; reset is synchronous and active-low.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `req0`, `req1`  in  1  access request; held with its fields stable until the matching ack.
- `we0`, `we1`  in  1  1 = write, 0 = read.
- `x0`, `x1`  in  AW_X  x address.
- `y0`, `y1`  in  AW_Y  y address.
- `wd0`, `wd1`  in  DW  write data.
- `ack0`, `ack1`  out  1  one-cycle completion pulse.
- `rdata`  out  DW  read data; valid while an ack is high after a read; otherwise holds its last value.
- `clr_start`  in  1  request a bulk clear (single-cycle pulse).
- `clr_done`  out  1  one-cycle pulse after the last location has been cleared.
- `busy`  out  1  high in any state other than IDLE.
- `mem_addr_x`  out  AW_X  to `mem2d` `addr_x` (registered).
- `mem_addr_y`  out  AW_Y  to `mem2d` `addr_y` (registered).
- `mem_data_in`  out  DW  to `mem2d` `data_in` (registered).
- `mem_wr`  out  1  to `mem2d` `wr` (registered).
- `mem_data_out`  in  DW  from `mem2d` `data_out`; combinational read of the current address.

## Operation
- **States:** IDLE, SETUP, STROBE, DONE, CLR_SETUP, CLR_STROBE, CLR_DONE.
- **IDLE**
  - If a clear is pending (`clr_start` this cycle or the `clr_pend` latch), go to CLR_SETUP. Clear has priority over requests.
  - Otherwise, if any request is active, pick a winner, register its fields, and go to SETUP.
- **Round-robin:** `last` register, reset value 1.
  - If both requesters are active, grant the one that is not `last`.
  - If only one is active, grant it.
  - `last` updates on every grant.
- **SETUP:** drive `mem_addr_x/y` and `mem_data_in` from the latched request with `mem_wr`=0. Go to STROBE.
- **STROBE:** `mem_wr` = latched `we`; address and data unchanged. Capture `mem_data_out` into `rdata` if it is a read. Go to DONE.
- **DONE:**
  - Assert `ack` for the winner and set `mem_wr`=0.
  - Requests are not sampled in DONE, so the requester deasserts `req` at or before the following edge.
  - Go to IDLE.
- **CLR_SETUP / CLR_STROBE:**
  - An (AW_X+AW_Y)-bit counter `{y,x}` starts at 0; `x` is the low part.
  - `mem_data_in`=0.
  - CLR_SETUP drives the address with `mem_wr`=0. CLR_STROBE sets `mem_wr`=1.
  - After CLR_STROBE: if the counter is at its maximum (x=63, y=31), go to CLR_DONE. Otherwise increment and go to CLR_SETUP.
- **CLR_DONE:** `clr_done`=1 for one cycle, clear `clr_pend`, go to IDLE.
- **`clr_start` outside IDLE and the clear states:** sets `clr_pend`; the clear is serviced at the next IDLE.
- **`clr_start` during CLR_*:** ignored.
- **Requests during a clear:** held off; no ack until the clear completes.
- **Synchronous reset (including mid-access or mid-clear):**
  - Return to IDLE.
  - Aborted operation produces no ack and no `clr_done`.
  - Reset values: `clr_pend`=0, `last`=1, counter=0.
  - All outputs are 0: `ack0/1`, `clr_done`, `busy`, `rdata`, `mem_addr_x/y`, `mem_data_in`, `mem_wr`.

## Timing
- Request sampled in IDLE at edge E. Then SETUP is in E+1, STROBE in E+2, and ack in E+3. Ack latency is 3 cycles.
- Back-to-back throughput: one access per 4 cycles (IDLE, SETUP, STROBE, DONE).
- `mem_wr` is high for exactly one cycle per write. Address and data are stable for one full cycle before `mem_wr` and during it.
- Read data is sampled at the end of STROBE and presented with the ack in DONE.
- Clear duration: 2 x 2^(AW_X+AW_Y) = 4096 cycles of CLR_SETUP/CLR_STROBE, plus 1 CLR_DONE cycle.
- `clr_start` sampled in IDLE at E gives CLR_SETUP in E+1 and `clr_done` in E+4097.
- `busy` is high from the cycle after the sampling edge until the end of DONE or CLR_DONE.

## Test plan
- **Single write:** `req0`, `we0`=1, x=10, y=5, `wd0`=0xAA.
  - SETUP shows `mem_addr_x`=10, `mem_addr_y`=5, `mem_wr`=0.
  - The next cycle has `mem_wr`=1, then `ack0` is high for 1 cycle.
  - Overall, `ack0` is high 3 cycles after the sampling edge.
- **Readback:** `req1`, `we1`=0, x=10, y=5 after the write above → `ack1` with `rdata`=0xAA; `mem_wr` stays 0 throughout.
- **Contention:** `req0` and `req1` asserted together and held, after reset.
  - Grants go 0 then 1 then 0.
  - Each access takes 4 cycles; acks alternate.
- **Bulk clear:**
  - Write 0x55 to (63,31) and 0x11 to (0,0).
  - Pulse `clr_start` → `clr_done` 4097 cycles later.
  - Reads of both locations then return 0x00.
- **Clear during access:** pulse `clr_start` while in STROBE, with `req1` pending.
  - The current ack completes.
  - The clear runs next, ahead of `req1`.
  - `ack1` follows `clr_done`.
- **Reset mid-clear:** drive `rst_n` low at counter 100 → next cycle all outputs are 0 and state is IDLE, with no `clr_done` pulse. A new request then completes normally.

Source files
------------

// File: rtl/mem2d_ctrl_if.sv
// mem2d_ctrl_if: requester, bulk-clear and mem2d port bundle.
// The controller takes the slave view; requesters and the memory take the master view.
interface mem2d_ctrl_if #(
    parameter int AW_X = 6,
    parameter int AW_Y = 5,
    parameter int DW   = 8
);
    logic            req0;
    logic            req1;
    logic            we0;
    logic            we1;
    logic [AW_X-1:0] x0;
    logic [AW_X-1:0] x1;
    logic [AW_Y-1:0] y0;
    logic [AW_Y-1:0] y1;
    logic [DW-1:0]   wd0;
    logic [DW-1:0]   wd1;
    logic            ack0;
    logic            ack1;
    logic [DW-1:0]   rdata;
    logic            clr_start;
    logic            clr_done;
    logic            busy;
    logic [AW_X-1:0] mem_addr_x;
    logic [AW_Y-1:0] mem_addr_y;
    logic [DW-1:0]   mem_data_in;
    logic            mem_wr;
    logic [DW-1:0]   mem_data_out;

    modport slave (
        input  req0, req1, we0, we1, x0, x1, y0, y1, wd0, wd1,
        input  clr_start, mem_data_out,
        output ack0, ack1, rdata, clr_done, busy,
        output mem_addr_x, mem_addr_y, mem_data_in, mem_wr
    );

    modport master (
        output req0, req1, we0, we1, x0, x1, y0, y1, wd0, wd1,
        output clr_start, mem_data_out,
        input  ack0, ack1, rdata, clr_done, busy,
        input  mem_addr_x, mem_addr_y, mem_data_in, mem_wr
    );
endinterface

// File: rtl/mem2d_ctrl.sv
// mem2d_ctrl: two-requester round-robin access controller for mem2d.
// Each access is IDLE/SETUP/STROBE/DONE; a bulk clear sweeps every cell to 0.
module mem2d_ctrl #(
    parameter int AW_X = 6,
    parameter int AW_Y = 5,
    parameter int DW   = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    mem2d_ctrl_if.slave  bus
);
    localparam int CW = AW_X + AW_Y;
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_DONE,
        S_CLR_SETUP,
        S_CLR_STROBE,
        S_CLR_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_last;
    logic            r_clr_pend;
    logic            r_sel;
    logic            r_we;
    logic [CW-1:0]   r_cnt;
    logic [DW-1:0]   r_rdata;
    logic            r_ack0;
    logic            r_ack1;
    logic            r_clr_done;
    logic            r_busy;
    logic            r_mem_wr;
    logic [AW_X-1:0] r_mem_x;
    logic [AW_Y-1:0] r_mem_y;
    logic [DW-1:0]   r_mem_d;

    logic            w_last_nxt;
    logic            w_pend_nxt;
    logic            w_sel_nxt;
    logic            w_we_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [CW-1:0]   w_cnt_inc;
    logic [DW-1:0]   w_rdata_nxt;
    logic            w_ack0_nxt;
    logic            w_ack1_nxt;
    logic            w_clr_done_nxt;
    logic            w_mem_wr_nxt;
    logic [AW_X-1:0] w_mem_x_nxt;
    logic [AW_Y-1:0] w_mem_y_nxt;
    logic [DW-1:0]   w_mem_d_nxt;
    logic            w_clr_go;
    logic            w_win;

    assign w_clr_go  = bus.clr_start | r_clr_pend;
    assign w_win     = (bus.req0 && bus.req1) ? ~r_last : bus.req1;
    assign w_cnt_inc = r_cnt + CNT_ONE;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus next value of every registered output
    always_comb begin
        w_state_nxt    = r_state;
        w_last_nxt     = r_last;
        w_pend_nxt     = r_clr_pend;
        w_sel_nxt      = r_sel;
        w_we_nxt       = r_we;
        w_cnt_nxt      = r_cnt;
        w_rdata_nxt    = r_rdata;
        w_ack0_nxt     = 1'b0;
        w_ack1_nxt     = 1'b0;
        w_clr_done_nxt = 1'b0;
        w_mem_wr_nxt   = 1'b0;
        w_mem_x_nxt    = r_mem_x;
        w_mem_y_nxt    = r_mem_y;
        w_mem_d_nxt    = r_mem_d;
        unique case (r_state)
            S_IDLE: begin
                if (w_clr_go) begin
                    w_state_nxt = S_CLR_SETUP;
                    w_cnt_nxt   = '0;
                    w_mem_x_nxt = '0;
                    w_mem_y_nxt = '0;
                    w_mem_d_nxt = '0;
                end else if (bus.req0 || bus.req1) begin
                    w_state_nxt = S_SETUP;
                    w_sel_nxt   = w_win;
                    w_last_nxt  = w_win;
                    w_we_nxt    = w_win ? bus.we1 : bus.we0;
                    w_mem_x_nxt = w_win ? bus.x1 : bus.x0;
                    w_mem_y_nxt = w_win ? bus.y1 : bus.y0;
                    w_mem_d_nxt = w_win ? bus.wd1 : bus.wd0;
                end
            end
            S_SETUP: begin
                w_state_nxt  = S_STROBE;
                w_mem_wr_nxt = r_we;
                w_pend_nxt   = r_clr_pend | bus.clr_start;
            end
            S_STROBE: begin
                w_state_nxt = S_DONE;
                w_ack0_nxt  = ~r_sel;
                w_ack1_nxt  = r_sel;
                w_pend_nxt  = r_clr_pend | bus.clr_start;
                if (!r_we) begin
                    w_rdata_nxt = bus.mem_data_out;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_pend_nxt  = r_clr_pend | bus.clr_start;
            end
            S_CLR_SETUP: begin
                w_state_nxt  = S_CLR_STROBE;
                w_mem_wr_nxt = 1'b1;
            end
            S_CLR_STROBE: begin
                if (&r_cnt) begin
                    w_state_nxt    = S_CLR_DONE;
                    w_clr_done_nxt = 1'b1;
                    w_cnt_nxt      = '0;
                end else begin
                    w_state_nxt = S_CLR_SETUP;
                    w_cnt_nxt   = w_cnt_inc;
                    w_mem_x_nxt = w_cnt_inc[AW_X-1:0];
                    w_mem_y_nxt = w_cnt_inc[CW-1:AW_X];
                end
            end
            S_CLR_DONE: begin
                w_state_nxt = S_IDLE;
                w_pend_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output and bookkeeping registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last     <= 1'b1;
            r_clr_pend <= 1'b0;
            r_sel      <= 1'b0;
            r_we       <= 1'b0;
            r_cnt      <= '0;
            r_rdata    <= '0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_clr_done <= 1'b0;
            r_busy     <= 1'b0;
            r_mem_wr   <= 1'b0;
            r_mem_x    <= '0;
            r_mem_y    <= '0;
            r_mem_d    <= '0;
        end else begin
            r_last     <= w_last_nxt;
            r_clr_pend <= w_pend_nxt;
            r_sel      <= w_sel_nxt;
            r_we       <= w_we_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rdata    <= w_rdata_nxt;
            r_ack0     <= w_ack0_nxt;
            r_ack1     <= w_ack1_nxt;
            r_clr_done <= w_clr_done_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
            r_mem_wr   <= w_mem_wr_nxt;
            r_mem_x    <= w_mem_x_nxt;
            r_mem_y    <= w_mem_y_nxt;
            r_mem_d    <= w_mem_d_nxt;
        end
    end

    assign bus.ack0        = r_ack0;
    assign bus.ack1        = r_ack1;
    assign bus.rdata       = r_rdata;
    assign bus.clr_done    = r_clr_done;
    assign bus.busy        = r_busy;
    assign bus.mem_wr      = r_mem_wr;
    assign bus.mem_addr_x  = r_mem_x;
    assign bus.mem_addr_y  = r_mem_y;
    assign bus.mem_data_in = r_mem_d;
endmodule

// File: tb/tb_mem2d_ctrl.sv
// tb_mem2d_ctrl: random and directed accesses/clears against a
// transaction-level reference of the 64x32x8 memory and round-robin rule.
module tb_mem2d_ctrl;
    localparam int AW_X = 6;
    localparam int AW_Y = 5;
    localparam int DW   = 8;
    localparam int N    = 2048;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem2d_ctrl_if #(.AW_X(AW_X), .AW_Y(AW_Y), .DW(DW)) bus ();

    mem2d_ctrl #(.AW_X(AW_X), .AW_Y(AW_Y), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural mem2d: synchronous write, combinational read
    logic [DW-1:0] mem [N];
    always @(posedge clk) begin
        if (bus.mem_wr) mem[{bus.mem_addr_y, bus.mem_addr_x}] <= bus.mem_data_in;
    end
    assign bus.mem_data_out = mem[{bus.mem_addr_y, bus.mem_addr_x}];

    int n_chk = 0;
    int n_err = 0;

    logic [DW-1:0]   ref_mem [N];
    bit              m_last;
    bit              f_we [2];
    logic [AW_X-1:0] f_x  [2];
    logic [AW_Y-1:0] f_y  [2];
    logic [DW-1:0]   f_wd [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic put_fields();
        bus.we0 = f_we[0]; bus.x0 = f_x[0]; bus.y0 = f_y[0]; bus.wd0 = f_wd[0];
        bus.we1 = f_we[1]; bus.x1 = f_x[1]; bus.y1 = f_y[1]; bus.wd1 = f_wd[1];
    endtask

    task automatic clr_ref(input int upto);
        for (int i = 0; i <= upto; i++) ref_mem[i] = '0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk(tag, {bus.ack0, bus.ack1, bus.clr_done, bus.busy, bus.mem_wr,
                  bus.rdata, bus.mem_addr_x, bus.mem_addr_y, bus.mem_data_in}, 32'd0);
    endtask

    // One round: port 0 and/or port 1 request together; grant order from the model
    task automatic serve(input bit u0, input bit u1);
        int order[$];
        int n;
        int g;
        bit got;
        bit drop [2];
        logic [19:0] h1, h2, cur;
        logic [10:0] a;
        drop[0] = 1'b0; drop[1] = 1'b0;
        h1 = '0; h2 = '0;
        if (u0 && u1) begin
            order.push_back(m_last ? 0 : 1);
            order.push_back(m_last ? 1 : 0);
        end else begin
            order.push_back(u1 ? 1 : 0);
        end
        @(posedge clk); #1;
        put_fields();
        bus.req0 = u0; bus.req1 = u1;
        for (int k = 0; k < order.size(); k++) begin
            g = order[k]; n = 0; got = 1'b0;
            while (!got && n < 20) begin
                @(posedge clk);
                if (drop[0]) begin #1; bus.req0 = 1'b0; drop[0] = 1'b0; end
                if (drop[1]) begin #1; bus.req1 = 1'b0; drop[1] = 1'b0; end
                n++;
                @(negedge clk);
                cur = {bus.mem_wr, bus.mem_data_in, bus.mem_addr_y, bus.mem_addr_x};
                if (bus.ack0 || bus.ack1) got = 1'b1;
                else begin h2 = h1; h1 = cur; end
            end
            chk("ack_seen", {31'd0, got}, 32'd1);
            if (!got) break;
            a = {f_y[g], f_x[g]};
            chk("ack_lat", n, (k == 0) ? 32'd3 : 32'd4);
            chk("ack_who", {bus.ack1, bus.ack0}, (g == 1) ? 32'd2 : 32'd1);
            chk("busy_done", {31'd0, bus.busy}, 32'd1);
            chk("wr_done", {31'd0, bus.mem_wr}, 32'd0);
            chk("setup_phase", {h2[19], h2[10:0]}, {20'd0, 1'b0, a});
            chk("strobe_phase", {h1[19], h1[10:0]}, {20'd0, f_we[g], a});
            if (f_we[g]) begin
                chk("strobe_data", h1[18:11], f_wd[g]);
                ref_mem[a] = f_wd[g];
            end else begin
                chk("rdata", bus.rdata, ref_mem[a]);
            end
            m_last = (g == 1);
            drop[g] = 1'b1;
        end
        @(posedge clk); #1;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
    endtask

    initial begin
        int n;
        int wrs;
        int bad;
        int mode;
        bit got;
        int t_a0, t_dn, t_a1, n_a0;
        logic [DW-1:0] rd1;
        logic [DW-1:0] v;

        for (int i = 0; i < N; i++) begin
            v = DW'($urandom);
            mem[i] <= v;
            ref_mem[i] = v;
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.clr_start = 1'b0;
        for (int p = 0; p < 2; p++) begin
            f_we[p] = 1'b0; f_x[p] = '0; f_y[p] = '0; f_wd[p] = '0;
        end
        put_fields();
        m_last = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outs("reset_outs");
        @(posedge clk); #1 rst_n = 1'b1;

        // Contention: both held, grants 0,1,0 at 4-cycle spacing
        f_we[0] = 1'b0; f_x[0] = 6'd1; f_y[0] = 5'd2;
        f_we[1] = 1'b0; f_x[1] = 6'd3; f_y[1] = 5'd4;
        @(posedge clk); #1;
        put_fields();
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("rr_c%0d", c), {bus.ack1, bus.ack0},
                (c == 3 || c == 11) ? 32'd1 : (c == 7) ? 32'd2 : 32'd0);
            if (c == 3 || c == 11) chk("rr_rd0", bus.rdata, ref_mem[{5'd2, 6'd1}]);
            if (c == 7) chk("rr_rd1", bus.rdata, ref_mem[{5'd4, 6'd3}]);
        end
        @(posedge clk); #1;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        m_last = 1'b0;

        // Single write then readback from the other port
        f_we[0] = 1'b1; f_x[0] = 6'd10; f_y[0] = 5'd5; f_wd[0] = 8'hAA;
        serve(1'b1, 1'b0);
        f_we[1] = 1'b0; f_x[1] = 6'd10; f_y[1] = 5'd5;
        serve(1'b0, 1'b1);
        chk("readback_aa", bus.rdata, 32'hAA);

        // Bulk clear
        f_we[0] = 1'b1; f_x[0] = 6'd63; f_y[0] = 5'd31; f_wd[0] = 8'h55;
        serve(1'b1, 1'b0);
        f_we[1] = 1'b1; f_x[1] = 6'd0; f_y[1] = 5'd0; f_wd[1] = 8'h11;
        serve(1'b0, 1'b1);
        @(posedge clk); #1 bus.clr_start = 1'b1;
        @(posedge clk); #1 bus.clr_start = 1'b0;
        n = 0; wrs = 0; bad = 0; got = 1'b0;
        while (!got && n < 5000) begin
            @(negedge clk);
            if (bus.mem_wr) begin
                wrs++;
                if (bus.mem_data_in != '0) bad++;
            end
            if (!bus.busy) bad++;
            if (bus.clr_done) got = 1'b1;
            else begin @(posedge clk); n++; end
        end
        chk("clr_seen", {31'd0, got}, 32'd1);
        chk("clr_lat", n, 32'd4096);
        chk("clr_writes", wrs, 32'd2048);
        chk("clr_bad", bad, 32'd0);
        clr_ref(N - 1);
        bad = 0;
        for (int i = 0; i < N; i++) if (mem[i] != '0) bad++;
        chk("clr_cells", bad, 32'd0);
        f_we[0] = 1'b0; f_x[0] = 6'd63; f_y[0] = 5'd31;
        serve(1'b1, 1'b0);
        chk("clr_rd_max", bus.rdata, 32'd0);
        f_we[1] = 1'b0; f_x[1] = 6'd0; f_y[1] = 5'd0;
        serve(1'b0, 1'b1);
        chk("clr_rd_zero", bus.rdata, 32'd0);

        // Clear pulsed during STROBE with req1 waiting
        f_we[0] = 1'b1; f_x[0] = 6'd7; f_y[0] = 5'd3; f_wd[0] = 8'h3C;
        f_we[1] = 1'b0; f_x[1] = 6'd7; f_y[1] = 5'd3;
        @(posedge clk); #1;
        put_fields();
        bus.req0 = 1'b1;
        @(posedge clk); #1 bus.req1 = 1'b1;
        @(posedge clk); #1 bus.clr_start = 1'b1;
        @(posedge clk); #1 bus.clr_start = 1'b0;
        t_a0 = -1; t_dn = -1; t_a1 = -1; n_a0 = 0; rd1 = '0;
        for (int c = 0; c < 6000 && t_a1 < 0; c++) begin
            @(negedge clk);
            if (bus.ack0) begin n_a0++; if (t_a0 < 0) t_a0 = c; end
            if (bus.clr_done && t_dn < 0) t_dn = c;
            if (bus.ack1) begin t_a1 = c; rd1 = bus.rdata; end
            @(posedge clk); #1;
            if (bus.ack0) bus.req0 = 1'b0;
            if (bus.ack1) bus.req1 = 1'b0;
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        chk("cda_ack0_t", t_a0, 32'd0);
        chk("cda_ack0_n", n_a0, 32'd1);
        chk("cda_done_t", t_dn - t_a0, 32'd4098);
        chk("cda_ack1_t", t_a1 - t_dn, 32'd4);
        chk("cda_rdata", rd1, 32'd0);
        clr_ref(N - 1);
        m_last = 1'b1;

        // Random rounds, addresses biased to a small window for read-after-write
        for (int r = 0; r < 40; r++) begin
            for (int p = 0; p < 2; p++) begin
                f_we[p] = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) != 0) begin
                    f_x[p] = 6'($urandom_range(0, 3));
                    f_y[p] = 5'($urandom_range(0, 1));
                end else begin
                    f_x[p] = 6'($urandom);
                    f_y[p] = 5'($urandom);
                end
                f_wd[p] = 8'($urandom);
            end
            mode = $urandom_range(0, 2);
            serve(mode != 1, mode != 0);
        end

        // Reset in the middle of a clear
        @(posedge clk); #1 bus.clr_start = 1'b1;
        @(posedge clk); #1 bus.clr_start = 1'b0;
        n = 0; got = 1'b0;
        while (!got && n < 1000) begin
            @(negedge clk);
            if ({bus.mem_addr_y, bus.mem_addr_x} == 11'd100 && !bus.mem_wr) got = 1'b1;
            else begin @(posedge clk); n++; end
        end
        chk("rst_cnt100", {31'd0, got}, 32'd1);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_reset_outs("rst_mid_outs");
        @(posedge clk); #1 rst_n = 1'b1;
        clr_ref(100);
        m_last = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.clr_done || bus.ack0 || bus.ack1 || bus.busy) bad++;
        end
        chk("rst_quiet", bad, 32'd0);
        f_we[0] = 1'b1; f_x[0] = 6'd9; f_y[0] = 5'd9; f_wd[0] = 8'hC3;
        f_we[1] = 1'b0; f_x[1] = 6'd9; f_y[1] = 5'd9;
        serve(1'b1, 1'b1);
        chk("rst_rd_after", bus.rdata, 32'hC3);
        f_we[1] = 1'b0; f_x[1] = 6'd2; f_y[1] = 5'd0;
        serve(1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
